// File: rtl/ssi_encoder_slave_if.sv
// rtl/ssi_encoder_slave_if.sv - SSI clock/data pair between reader (master) and encoder emulator (slave)
interface ssi_encoder_slave_if;
    logic ssi_c;
    logic ssi_d;

    modport master (output ssi_c, input ssi_d);
    modport slave  (input ssi_c, output ssi_d);
endinterface

// File: rtl/ssi_encoder_slave.sv
// rtl/ssi_encoder_slave.sv - SSI absolute-encoder emulator serialising pos_in MSB first
module ssi_encoder_slave #(
    parameter int DATA_BITS      = 28,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int GRAY           = 0
) (
    input  logic                 clk_100m,
    input  logic                 rst_n_syn,
    input  logic [DATA_BITS-1:0] pos_in,
    ssi_encoder_slave_if.slave   ssi,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 clk_err,
    output logic [15:0]          frame_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] N_BITS = CW'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, MONO} state_t;

    state_t               state, state_n;
    logic                 sync1, sync2, hist;
    logic [TW-1:0]        timer, timer_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [CW-1:0]        bit_cnt, bit_cnt_n;
    logic                 ssi_d_q, ssi_d_n;
    logic                 busy_n, done_n, err_n;
    logic [15:0]          fcnt_q, fcnt_n;
    logic                 fall, rise, timeout;
    logic [DATA_BITS-1:0] load_word;

    assign fall      = hist & ~sync2;
    assign rise      = ~hist & sync2;
    assign timeout   = (timer == T_MAX);
    assign load_word = (GRAY != 0) ? (pos_in ^ (pos_in >> 1)) : pos_in;

    assign ssi.ssi_d = ssi_d_q;
    assign frame_cnt = fcnt_q;

    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            hist       <= 1'b1;
            state      <= IDLE;
            timer      <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            ssi_d_q    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            clk_err    <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            sync1      <= ssi.ssi_c;
            sync2      <= sync1;
            hist       <= sync2;
            state      <= state_n;
            timer      <= timer_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            ssi_d_q    <= ssi_d_n;
            busy       <= busy_n;
            frame_done <= done_n;
            clk_err    <= err_n;
            fcnt_q     <= fcnt_n;
        end
    end

    // Monoflop timer: runs only while the master clock sits high, restarts on every edge.
    always_comb begin
        timer_n = timer;
        if (state == IDLE || fall || rise)
            timer_n = '0;
        else if (sync2 && !timeout)
            timer_n = timer + 1'b1;
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        ssi_d_n   = ssi_d_q;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        fcnt_n    = fcnt_q;
        case (state)
            IDLE: begin
                ssi_d_n = 1'b1;
                busy_n  = 1'b0;
                if (fall) begin
                    shreg_n   = load_word;
                    bit_cnt_n = '0;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (timeout) begin
                    err_n   = 1'b1;
                    ssi_d_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (rise) begin
                    if (bit_cnt == N_BITS) begin
                        ssi_d_n = 1'b0;
                        state_n = MONO;
                    end else begin
                        ssi_d_n   = shreg[DATA_BITS-1];
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            MONO: begin
                ssi_d_n = 1'b0;
                if (fall) begin
                    err_n = 1'b1;
                end else if (timeout) begin
                    ssi_d_n = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    fcnt_n  = fcnt_q + 16'd1;
                    state_n = IDLE;
                end
            end
            default: begin
                ssi_d_n = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ssi_encoder_slave.sv
// tb/tb_ssi_encoder_slave.sv - scoreboard bench: SSI master model against binary and Gray encoder instances
module tb_ssi_encoder_slave;
    localparam int DB = 28;
    localparam int TO = 2000;
    localparam int H  = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DB-1:0] pos_in;
    logic          ssi_c;
    logic          busy_b, done_b, err_b, busy_g, done_g, err_g;
    logic [15:0]   cnt_b, cnt_g;
    logic [15:0]   exp_cnt;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_done = 0, n_err = 0, done_cyc = 0;

    logic [DB-1:0] q_b[$];
    logic [DB-1:0] q_g[$];

    always #5 clk = ~clk;

    ssi_encoder_slave_if if_b();
    ssi_encoder_slave_if if_g();
    assign if_b.ssi_c = ssi_c;
    assign if_g.ssi_c = ssi_c;

    ssi_encoder_slave #(.DATA_BITS(DB), .TIMEOUT_CYCLES(TO), .GRAY(0)) u_bin (
        .clk_100m(clk), .rst_n_syn(rst_n), .pos_in(pos_in), .ssi(if_b),
        .busy(busy_b), .frame_done(done_b), .clk_err(err_b), .frame_cnt(cnt_b)
    );

    ssi_encoder_slave #(.DATA_BITS(DB), .TIMEOUT_CYCLES(TO), .GRAY(1)) u_gray (
        .clk_100m(clk), .rst_n_syn(rst_n), .pos_in(pos_in), .ssi(if_g),
        .busy(busy_g), .frame_done(done_g), .clk_err(err_g), .frame_cnt(cnt_g)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_b) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (err_b) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [DB-1:0] to_gray(input logic [DB-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic push_exp(input logic [DB-1:0] b, input logic [DB-1:0] g);
        q_b.push_back(b);
        q_g.push_back(g);
    endtask

    // nbits < DB models a master that stops and parks the clock high; rst_at >= 0 resets mid-frame.
    task automatic run_frame(input int nbits, input int extra, input int rst_at,
                             input int chg_at, input logic [DB-1:0] chg_val);
        int d0, e0, rise_c;
        logic [DB-1:0] wb, wg, eb, eg;
        d0 = n_done;
        e0 = n_err;
        wb = '0;
        wg = '0;
        rise_c = cyc;
        @(negedge clk);
        ssi_c = 1'b0;
        wait_n(H);
        for (int i = 0; i < nbits; i++) begin
            ssi_c = 1'b1;
            if (i == rst_at) begin
                wait_n(H / 2);
                rst_n = 1'b0;
                #1;
                check("rst_ssi_d", 32'(if_b.ssi_d), 32'd1);
                check("rst_busy", 32'(busy_b), 32'd0);
                check("rst_ssi_d_gray", 32'(if_g.ssi_d), 32'd1);
                wait_n(3);
                rst_n = 1'b1;
                exp_cnt = '0;
                wait_n(5);
                return;
            end
            wait_n(H);
            ssi_c = 1'b0;
            wb = {wb[DB-2:0], if_b.ssi_d};
            wg = {wg[DB-2:0], if_g.ssi_d};
            if (i == chg_at) pos_in = chg_val;
            wait_n(H);
        end
        ssi_c = 1'b1;
        rise_c = cyc;
        for (int e = 0; e < extra; e++) begin
            wait_n(H);
            ssi_c = 1'b0;
            check("over_ssi_d", 32'(if_b.ssi_d), 32'd0);
            wait_n(H);
            ssi_c = 1'b1;
            rise_c = cyc;
        end
        for (int k = 0; k < TO + 200; k++) begin
            if (!busy_b) break;
            @(negedge clk);
        end
        check("busy_wait", 32'(busy_b), 32'd0);
        wait_n(2);
        if (nbits == DB) begin
            eb = q_b.pop_front();
            eg = q_g.pop_front();
            exp_cnt = exp_cnt + 16'd1;
            check("word_bin", 32'(wb), 32'(eb));
            check("word_gray", 32'(wg), 32'(eg));
            check("done_pulses", 32'(n_done - d0), 32'd1);
            check("err_pulses", 32'(n_err - e0), 32'(extra));
            check("frame_cnt", 32'(cnt_b), 32'(exp_cnt));
            check("frame_cnt_gray", 32'(cnt_g), 32'(exp_cnt));
            check("done_delay_ok", 32'((done_cyc - rise_c >= TO) && (done_cyc - rise_c <= TO + 6)), 32'd1);
            check("idle_ssi_d", 32'(if_b.ssi_d), 32'd1);
        end else begin
            check("abort_err", 32'(n_err - e0), 32'd1);
            check("abort_done", 32'(n_done - d0), 32'd0);
            check("abort_cnt", 32'(cnt_b), 32'(exp_cnt));
            check("abort_ssi_d", 32'(if_b.ssi_d), 32'd1);
            check("abort_busy", 32'(busy_b), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ssi_c   = 1'b1;
        rst_n   = 1'b0;
        pos_in  = '0;
        exp_cnt = '0;
        wait_n(5);
        check("reset_ssi_d", 32'(if_b.ssi_d), 32'd1);
        check("reset_busy", 32'(busy_b), 32'd0);
        check("reset_done", 32'(done_b), 32'd0);
        check("reset_err", 32'(err_b), 32'd0);
        check("reset_cnt", 32'(cnt_b), 32'd0);
        rst_n = 1'b1;
        wait_n(5);

        pos_in = 28'hA5C3E1F;
        push_exp(28'hA5C3E1F, to_gray(28'hA5C3E1F));
        run_frame(DB, 0, -1, -1, '0);

        pos_in = 28'h0000008;
        push_exp(28'h0000008, 28'h000000C);
        run_frame(DB, 0, -1, -1, '0);

        pos_in = 28'hFFFFFFF;
        push_exp(28'hFFFFFFF, 28'h8000000);
        run_frame(DB, 0, -1, -1, '0);

        pos_in = 28'h0F0F0F0;
        run_frame(10, 0, -1, -1, '0);

        pos_in = 28'h1234567;
        push_exp(28'h1234567, to_gray(28'h1234567));
        run_frame(DB, 0, -1, 5, 28'h7654321);
        push_exp(28'h7654321, to_gray(28'h7654321));
        run_frame(DB, 0, -1, -1, '0);

        pos_in = 28'h3333333;
        push_exp(28'h3333333, to_gray(28'h3333333));
        run_frame(DB, 3, -1, -1, '0);

        pos_in = 28'h5555555;
        run_frame(DB, 0, 12, -1, '0);
        check("post_rst_cnt", 32'(cnt_b), 32'd0);
        pos_in = 28'h2AAAAAA;
        push_exp(28'h2AAAAAA, to_gray(28'h2AAAAAA));
        run_frame(DB, 0, -1, -1, '0);

        @(negedge clk);
        force u_bin.fcnt_q = 16'hFFFF;
        force u_gray.fcnt_q = 16'hFFFF;
        wait_n(2);
        release u_bin.fcnt_q;
        release u_gray.fcnt_q;
        exp_cnt = 16'hFFFF;
        wait_n(2);
        check("preload_cnt", 32'(cnt_b), 32'h0000FFFF);
        pos_in = 28'h0C0FFEE;
        push_exp(28'h0C0FFEE, to_gray(28'h0C0FFEE));
        run_frame(DB, 0, -1, -1, '0);
        check("wrap_cnt", 32'(cnt_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end
endmodule
